// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared state encodings, BCD limits and tick defaults for the game timer blocks
package game_timer_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int TICKS_PER_SEC_DEF = 1000;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_down_counter_2d.sv
// bcd_down_counter_2d: two-digit BCD down counter with clamped load, decrement enable and zero-next flag
module bcd_down_counter_2d
  import game_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_tens_i,
  input  logic [3:0] load_ones_i,
  input  logic       dec_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       zero_next_o
);
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic       at_zero;
  always_comb begin
    at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    tens_d = clr_i ? 4'd0
           : load_i ? bcd_clamp(load_tens_i)
           : (dec_i && !at_zero && ones_q == 4'd0) ? tens_q - 4'd1
           : tens_q;
    ones_d = clr_i ? 4'd0
           : load_i ? bcd_clamp(load_ones_i)
           : (dec_i && !at_zero) ? ((ones_q == 4'd0) ? BCD_MAX : ones_q - 4'd1)
           : ones_q;
    zero_next_o = (tens_d == 4'd0) && (ones_d == 4'd0);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end
  assign tens_o = tens_q;
  assign ones_o = ones_q;
endmodule

// File: rtl/round_countdown_timer.sv
// round_countdown_timer: BCD seconds countdown driven by 1 ms ticks, with pause, restart and expiry pulse
module round_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       pause_i,
  input  logic [3:0] load_tens_i,
  input  logic [3:0] load_ones_i,
  input  logic       ms_tick_i,
  output logic       ms_enable_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       running_o,
  output logic       done_o,
  output logic       expired_o
);
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ms_cnt_q, ms_cnt_d;
  logic          running_q, done_q, expired_q, ms_enable_q, expired_d;
  logic          st_run, counting, clr, load, dec, zero_next;
  always_comb begin
    st_run = state_q == ST_RUN;
    counting = !abort_i && !start_i && st_run && !pause_i && ms_tick_i;
    clr = abort_i;
    load = !abort_i && start_i;
    dec = counting && (ms_cnt_q == CW'(TICKS_PER_SEC - 1));
    ms_cnt_d = (abort_i || start_i || dec) ? '0 : counting ? ms_cnt_q + CW'(1) : ms_cnt_q;
  end
  bcd_down_counter_2d u_digits (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .load_i      (load),
    .load_tens_i (load_tens_i),
    .load_ones_i (load_ones_i),
    .dec_i       (dec),
    .tens_o      (sec_tens_o),
    .ones_o      (sec_ones_o),
    .zero_next_o (zero_next)
  );
  // Loading or decrementing to 00 lands directly in DONE with a single expiry pulse
  always_comb begin
    expired_d = (load || dec) && zero_next;
    state_d = abort_i ? ST_IDLE
            : (load || dec) ? (zero_next ? ST_DONE : ST_RUN)
            : (st_run && pause_i) ? ST_PAUSED
            : (state_q == ST_PAUSED && !pause_i) ? ST_RUN
            : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ms_cnt_q <= '0;
      running_q <= 1'b0;
      done_q <= 1'b0;
      expired_q <= 1'b0;
      ms_enable_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_cnt_q <= ms_cnt_d;
      running_q <= state_d == ST_RUN;
      done_q <= state_d == ST_DONE;
      expired_q <= expired_d;
      ms_enable_q <= state_d == ST_RUN;
    end
  end
  assign running_o = running_q;
  assign done_o = done_q;
  assign expired_o = expired_q;
  assign ms_enable_o = ms_enable_q;
endmodule

// File: tb/tb_round_countdown_timer.sv
// tb_round_countdown_timer: random and directed stimulus checked every cycle against a seconds-level model
module tb_round_countdown_timer;
  localparam int TPS = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  logic clk = 0, rst = 1, start_i = 0, abort_i = 0, pause_i = 0, ms_tick_i = 0;
  logic [3:0] load_tens_i = 0, load_ones_i = 0;
  logic ms_enable_o, running_o, done_o, expired_o;
  logic [3:0] sec_tens_o, sec_ones_o;
  int checks = 0, passes = 0;
  int m_mode = M_IDLE, m_rem = 0, m_cnt = 0;
  bit m_exp = 0, prev_exp = 0, armed = 0, auto_tick = 0;
  int ph = 0;

  round_countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .pause_i(pause_i),
    .load_tens_i(load_tens_i), .load_ones_i(load_ones_i), .ms_tick_i(ms_tick_i),
    .ms_enable_o(ms_enable_o), .sec_tens_o(sec_tens_o), .sec_ones_o(sec_ones_o),
    .running_o(running_o), .done_o(done_o), .expired_o(expired_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", n, got, exp);
  endtask

  // Model tracks remaining seconds as a plain integer and ticks within the current second
  always @(posedge clk) begin
    m_exp = 0;
    if (!rst || abort_i) begin
      m_mode = M_IDLE; m_rem = 0; m_cnt = 0;
    end else if (start_i) begin
      m_rem = (load_tens_i > 9 ? 9 : int'(load_tens_i)) * 10 + (load_ones_i > 9 ? 9 : int'(load_ones_i));
      m_cnt = 0;
      m_mode = (m_rem == 0) ? M_DONE : M_RUN;
      m_exp = (m_rem == 0);
    end else if (m_mode == M_RUN) begin
      if (pause_i) m_mode = M_PAUSED;
      else if (ms_tick_i) begin
        m_cnt++;
        if (m_cnt == TPS) begin
          m_cnt = 0;
          m_rem--;
          if (m_rem == 0) begin m_mode = M_DONE; m_exp = 1; end
        end
      end
    end else if (m_mode == M_PAUSED && !pause_i) m_mode = M_RUN;
  end

  always @(negedge clk) if (armed) begin
    chk("tens", sec_tens_o, m_rem / 10);
    chk("ones", sec_ones_o, m_rem % 10);
    chk("running", running_o, m_mode == M_RUN);
    chk("ms_enable", ms_enable_o, m_mode == M_RUN);
    chk("done", done_o, m_mode == M_DONE);
    chk("expired", expired_o, m_exp);
    if (prev_exp) chk("expired_twice", expired_o, 0);
    prev_exp = expired_o;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      start_i = 0; abort_i = 0;
      ph++;
      ms_tick_i = auto_tick && (ph % 5 == 0);
    end
  endtask

  task automatic do_start(input logic [3:0] t, input logic [3:0] o);
    load_tens_i = t; load_ones_i = o; start_i = 1;
    cyc(1);
  endtask

  task automatic tick();
    ms_tick_i = 1;
    cyc(2);
  endtask

  task automatic lit(input string n, input int t, input int o, input int run, input int dn, input int ex);
    chk({n, "_tens"}, sec_tens_o, t);
    chk({n, "_ones"}, sec_ones_o, o);
    chk({n, "_running"}, running_o, run);
    chk({n, "_done"}, done_o, dn);
    chk({n, "_expired"}, expired_o, ex);
  endtask

  initial begin
    rst = 0;
    cyc(2);
    rst = 1;
    armed = 1;
    lit("reset", 0, 0, 0, 0, 0);
    chk("reset_ms_enable", ms_enable_o, 0);
    chk("model_reset", m_rem, 0);
    // Basic countdown
    auto_tick = 1;
    do_start(0, 3);
    lit("basic_load", 0, 3, 1, 0, 0);
    chk("basic_ms_enable", ms_enable_o, 1);
    for (int i = 0; i < 200 && !expired_o; i++) cyc(1);
    lit("basic_end", 0, 0, 0, 1, 1);
    chk("basic_end_ms_enable", ms_enable_o, 0);
    chk("model_basic_end", m_rem, 0);
    cyc(1);
    lit("basic_after", 0, 0, 0, 1, 0);
    // BCD borrow and clamp
    do_start(1, 0);
    lit("borrow_load", 1, 0, 1, 0, 0);
    for (int i = 0; i < 100 && sec_tens_o != 0; i++) cyc(1);
    lit("borrow", 0, 9, 1, 0, 0);
    do_start(9, 15);
    lit("clamp", 9, 9, 1, 0, 0);
    chk("model_clamp", m_rem, 99);
    // Zero load
    do_start(0, 0);
    lit("zero", 0, 0, 0, 1, 1);
    cyc(1);
    lit("zero_after", 0, 0, 0, 1, 0);
    // Pause, with a tick coincident with the pause rising edge
    auto_tick = 0;
    cyc(1);
    do_start(0, 2);
    tick(); tick();
    pause_i = 1; ms_tick_i = 1;
    cyc(1);
    repeat (4) begin ms_tick_i = 1; cyc(5); end
    lit("paused", 0, 2, 0, 0, 0);
    chk("paused_ms_enable", ms_enable_o, 0);
    pause_i = 0;
    cyc(1);
    chk("resume_ms_enable", ms_enable_o, 1);
    tick();
    lit("resume_one_tick", 0, 2, 1, 0, 0);
    tick();
    lit("resume_two_ticks", 0, 1, 1, 0, 0);
    // Restart coincident with a tick, then abort
    do_start(0, 5);
    tick(); tick(); tick();
    ms_tick_i = 1;
    do_start(0, 7);
    lit("restart", 0, 7, 1, 0, 0);
    tick(); tick(); tick();
    lit("restart_three_ticks", 0, 7, 1, 0, 0);
    tick();
    lit("restart_four_ticks", 0, 6, 1, 0, 0);
    abort_i = 1;
    cyc(1);
    lit("abort", 0, 0, 0, 0, 0);
    // Reset mid-run
    do_start(0, 3);
    tick(); tick();
    rst = 0;
    cyc(1);
    rst = 1;
    lit("rst_mid", 0, 0, 0, 0, 0);
    repeat (6) tick();
    lit("rst_ignored", 0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) != 0);
      abort_i = ($urandom_range(0, 99) == 0);
      start_i = ($urandom_range(0, 39) == 0);
      load_tens_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      load_ones_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) pause_i = ~pause_i;
      ms_tick_i = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rst = 1; abort_i = 0; start_i = 0; pause_i = 0; ms_tick_i = 0;
    cyc(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/round_countdown_timer.md
# round_countdown_timer

Two-digit BCD seconds countdown for the memory-game round clock. It consumes the one-cycle 1 ms tick from the millisecond timer stage and drives that stage's enable. It accumulates ticks into seconds and decrements a loaded 00–99 value. It reports the remaining time to the seven-segment driver and pulses `expired` to the game FSM when the value reaches 00.

## Interface
- `TICKS_PER_SEC`, default 1000: ms ticks per decrement; reduced (e.g. 4) for simulation.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; loads `load_tens`/`load_ones` and starts or restarts the countdown.
- `abort` in 1: one-cycle pulse; returns to IDLE and clears digits.
- `pause` in 1: level; holds the countdown while high.
- `load_tens` in 4: BCD tens of the start value; values >9 are clamped to 9.
- `load_ones` in 4: BCD ones of the start value; values >9 are clamped to 9.
- `ms_tick` in 1: one-cycle 1 ms pulse from the upstream timer.
- `ms_enable` out 1: enable to the upstream ms timer.
- `sec_tens` out 4: remaining seconds, BCD tens.
- `sec_ones` out 4: remaining seconds, BCD ones.
- `running` out 1: high in RUN.
- `done` out 1: level, high in DONE.
- `expired` out 1: one-cycle pulse on reaching 00.

## Operation
- States:
  - IDLE: digits 00, `ms_enable`=0.
  - RUN: counting.
  - PAUSED: counting held, tick counter retained.
  - DONE: digits held at 00, `done`=1.
- Priority each cycle: `rst` > `abort` > `start` > `pause` > `ms_tick`.
- `abort` in any state → IDLE; digits 00, `ms_cnt` 0, no `expired`.
- `start` in any state:
  - Load clamped digits and clear `ms_cnt`.
  - Go to RUN.
  - If the loaded value is 00, go to DONE instead and pulse `expired`.
  - `start` in RUN restarts the countdown. A coincident `ms_tick` is dropped.
- RUN:
  - `pause`=1 → PAUSED.
  - Otherwise, on `ms_tick`: if `ms_cnt`==TICKS_PER_SEC−1, clear `ms_cnt` and BCD-decrement; else increment `ms_cnt`.
- BCD decrement: if ones==0, ones←9 and tens←tens−1; else ones←ones−1.
- A decrement producing 00 → DONE with an `expired` pulse.
- PAUSED:
  - `pause`=0 → RUN.
  - `ms_tick` is ignored.
  - Digits and `ms_cnt` are frozen.
- DONE: stays until `start` or `abort`; `ms_tick` is ignored.
- `ms_cnt` width is clog2(TICKS_PER_SEC). It never exceeds TICKS_PER_SEC−1.
- Upstream tick phase is not realigned on start. The first second may be short by up to one tick period; this is accepted.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `sec_tens`=0, `sec_ones`=0, `ms_cnt`=0, `ms_enable`=0, `running`=0, `done`=0, `expired`=0.
- `start` sampled at edge N: digits and `running` are valid after edge N; `ms_enable` is high from edge N.
- `ms_tick` completing a second at edge N: digits change after edge N.
- Final decrement at edge N:
  - Digits read 00 and `expired`=1 for exactly the cycle after edge N.
  - `done`=1 from the same cycle.
  - `running` and `ms_enable`=0 from the same cycle.
- `pause` rising at edge N: `ms_enable`=0 after edge N; a tick at edge N is not counted.
- `pause` falling at edge N: `ms_enable`=1 after edge N; counting resumes at edge N+1.
- `rst` low mid-countdown: all outputs take reset values after the next edge.
- `expired` never asserts two consecutive cycles.

## Structure
- Shared package/include `game_timer_pkg` holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3);
  - `BCD_MAX`=4'd9;
  - the default `TICKS_PER_SEC`.
- The seven-segment driver and game FSM use the same package.
- One sub-module: `bcd_down_counter_2d`. It provides load with clamp, a decrement enable, and a combinational zero-next flag.
- The FSM and `ms_cnt` accumulator stay in the top module.

## Test plan
All scenarios use TICKS_PER_SEC=4, with `ms_tick` every 5 cycles unless noted.
- **Basic countdown:** load 03, `start` → digits 03, 02, 01, 00 at 4-tick intervals. `expired` pulses once on 00; `done`=1; `ms_enable`=0.
- **BCD borrow:** load 10 → after 4 ticks digits read 09 (tens 0, ones 9). Load 9F → clamped to 99.
- **Zero load:** load 00, `start` → the next cycle shows DONE, `expired`=1 for one cycle, and `running` never asserts.
- **Pause:** load 02, tick twice, hold `pause` for 20 cycles with ticks present → digits stay 02 and `ms_enable`=0. Release → exactly 2 more ticks give 01.
- **Restart and coincidence:** in RUN at 05 with `ms_cnt`=3, assert `start` (load 07) in the same cycle as `ms_tick` → digits 07, `ms_cnt`=0, no decrement. `abort` then → IDLE, digits 00, no `expired`.
- **Reset mid-run:** drive `rst`=0 for one edge during RUN → all outputs at reset values. Subsequent ticks are ignored until `start`.
